// File: rtl/branch_predictor.sv
// branch_predictor: per-PC 2-bit saturating-counter predictor trained by EX, with a registered
// flush on mispredict and saturating branch/mispredict counters. Define BP_BTB_EN to add a tagged BTB.
module branch_predictor #(
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lk_valid,
    input  logic [31:0] lk_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic        upd_pred,
    input  logic [31:0] upd_target,
    output logic        flush,
    output logic [31:0] br_count,
    output logic [31:0] mp_count
);
    localparam int ENTRIES = 1 << IDX_BITS;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    ctr_e                ctr_q [ENTRIES];
    ctr_e                ctr_d [ENTRIES];
    logic                flush_q, flush_d;
    logic [31:0]         br_count_q, br_count_d;
    logic [31:0]         mp_count_q, mp_count_d;
    logic [IDX_BITS-1:0] lk_idx, upd_idx;
    logic [1:0]          lk_ctr;
    logic                mispredict;
    logic                btb_hit;

    assign lk_idx     = lk_pc[IDX_BITS+1:2];
    assign upd_idx    = upd_pc[IDX_BITS+1:2];
    assign mispredict = upd_valid & (upd_taken ^ upd_pred);

    always_comb begin
        // NOTE: defaults first -- every path assigns every output, so no latch is inferred.
        ctr_d      = ctr_q;
        flush_d    = mispredict;
        br_count_d = br_count_q;
        mp_count_d = mp_count_q;
        if (upd_valid) begin
            unique case (ctr_q[upd_idx])
                SNT: ctr_d[upd_idx] = upd_taken ? WNT : SNT;
                WNT: ctr_d[upd_idx] = upd_taken ? WT  : SNT;
                WT:  ctr_d[upd_idx] = upd_taken ? ST  : WNT;
                ST:  ctr_d[upd_idx] = upd_taken ? ST  : WT;
            endcase
            if (br_count_q != '1) br_count_d = br_count_q + 32'd1;
        end
        if (mispredict && mp_count_q != '1) mp_count_d = mp_count_q + 32'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WNT;
            flush_q    <= 1'b0;
            br_count_q <= '0;
            mp_count_q <= '0;
        end else begin
            ctr_q      <= ctr_d;
            flush_q    <= flush_d;
            br_count_q <= br_count_d;
            mp_count_q <= mp_count_d;
        end
    end

`ifdef BP_BTB_EN
    logic [ENTRIES-1:0]  btb_valid_q, btb_valid_d;
    logic [TAG_BITS-1:0] btb_tag_q    [ENTRIES];
    logic [TAG_BITS-1:0] btb_tag_d    [ENTRIES];
    logic [31:0]         btb_target_q [ENTRIES];
    logic [31:0]         btb_target_d [ENTRIES];
    logic [TAG_BITS-1:0] lk_tag, upd_tag;
    logic                unused_pc_bits;

    assign lk_tag  = lk_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign upd_tag = upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

    always_comb begin
        btb_valid_d  = btb_valid_q;
        btb_tag_d    = btb_tag_q;
        btb_target_d = btb_target_q;
        if (upd_valid && upd_taken) begin
            btb_valid_d[upd_idx]  = 1'b1;
            btb_tag_d[upd_idx]    = upd_tag;
            btb_target_d[upd_idx] = upd_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) btb_valid_q <= '0;
        else     btb_valid_q <= btb_valid_d;
    end

    // NOTE: tag/target arrays are not reset; the reset valid bits keep stale contents from ever hitting.
    always_ff @(posedge clk) begin
        btb_tag_q    <= btb_tag_d;
        btb_target_q <= btb_target_d;
    end

    assign btb_hit        = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
    assign pred_target    = btb_hit ? btb_target_q[lk_idx] : 32'h0;
    assign unused_pc_bits = ^{lk_pc[31:IDX_BITS+TAG_BITS+2], lk_pc[1:0],
                              upd_pc[31:IDX_BITS+TAG_BITS+2], upd_pc[1:0]};
`else
    logic unused_pc_bits;

    assign btb_hit        = 1'b1;
    assign pred_target    = 32'h0;
    assign unused_pc_bits = ^{lk_pc[31:IDX_BITS+2], lk_pc[1:0],
                              upd_pc[31:IDX_BITS+2], upd_pc[1:0], upd_target};
`endif

    assign lk_ctr     = ctr_q[lk_idx];
    assign pred_taken = lk_valid & lk_ctr[1] & btb_hit;
    assign flush      = flush_q;
    assign br_count   = br_count_q;
    assign mp_count   = mp_count_q;

endmodule
